// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: fetch FSM state
// encoding, default reset PC, canonical NOP word and PC helpers.
package inst_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Force a fetch address onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] pc_in);
        return {pc_in[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Instruction buffer: small circular FIFO with synchronous flush.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   flush         - drop all entries (wins over push/pop in the same cycle)
//   push, push_data - write one entry (ignored when full and not popping)
//   pop           - consume head entry (ignored when empty)
//   head_data     - head entry; holds the last shown head while empty
//   not_empty     - at least one entry present
//   count         - number of entries held
module inst_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     not_empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic [WIDTH-1:0] last_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against occupancy; a pop frees a slot for a same-cycle push.
    always_comb begin
        do_pop_s  = pop && (count_r != '0);
        do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
    end

    // Entry storage (data only, needs no reset).
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Remember the head currently presented so it stays visible once empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_r <= '0;
        end else if (count_r != '0) begin
            last_r <= mem_r[rd_ptr_r];
        end else begin
            last_r <= last_r;
        end
    end

    // Head presentation.
    always_comb begin
        count     = count_r;
        not_empty = (count_r != '0);
        if (count_r != '0) begin
            head_data = mem_r[rd_ptr_r];
        end else begin
            head_data = last_r;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues one word fetch at a time to instruction
// memory, buffers returned words with their PC for the decoder, and
// handles redirects (flush + discard of the in-flight response) and halt.
// Ports:
//   clk, rst_n                         - clock, synchronous active-low reset
//   imem_req_valid/ready, imem_addr    - fetch request channel
//   imem_rsp_valid, imem_rdata         - fetch response channel
//   inst_valid/ready, inst, inst_pc    - buffered instruction to decode
//   redirect_valid, redirect_pc        - new fetch PC (flushes buffer)
//   halt                               - stop fetching (level)
//   halted                             - fetch stopped, nothing outstanding
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    fetch_state_e  state_r;
    fetch_state_e  state_nxt_s;
    logic [31:0]   pc_r;
    logic [31:0]   fetch_pc_r;
    logic          discard_r;

    logic          req_fire_s;
    logic          rsp_fire_s;
    logic          redirect_act_s;
    logic          fifo_free_s;
    logic          push_s;
    logic [63:0]   head_s;
    logic [CW-1:0] fifo_count_s;

    // Event decode; redirects are ignored once halted.
    always_comb begin
        req_fire_s     = (state_r == ST_REQ) && imem_req_ready;
        rsp_fire_s     = (state_r == ST_WAIT) && imem_rsp_valid;
        redirect_act_s = redirect_valid && (state_r != ST_HALT);
        fifo_free_s    = (fifo_count_s < FULL_CNT);
        // A response arriving alongside a redirect belongs to the old path.
        push_s         = rsp_fire_s && !discard_r && !redirect_act_s;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (halt) begin
                    state_nxt_s = ST_HALT;
                end else if (fifo_free_s || redirect_act_s) begin
                    // The response of the previous fetch is already in the
                    // buffer here, so occupancy covers the in-flight entry.
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (req_fire_s) begin
                    // An accepted request must be waited out even on halt/redirect.
                    state_nxt_s = ST_WAIT;
                end else if (halt) begin
                    state_nxt_s = ST_HALT;
                end else if (redirect_act_s) begin
                    // Drop valid for a cycle so the address never changes mid-request.
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt_s = halt ? ST_HALT : ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs, decoded from registered state.
    always_comb begin
        imem_req_valid = (state_r == ST_REQ);
        imem_addr      = pc_r;
        halted         = (state_r == ST_HALT);
    end

    // Fetch PC, PC of the outstanding request and stale-response flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r       <= RESET_PC;
            fetch_pc_r <= RESET_PC;
            discard_r  <= 1'b0;
        end else begin
            if (redirect_act_s) begin
                pc_r <= align_pc(redirect_pc);
            end else if (req_fire_s) begin
                pc_r <= pc_r + PC_STEP;
            end else begin
                pc_r <= pc_r;
            end

            if (req_fire_s) begin
                fetch_pc_r <= pc_r;
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end

            if (rsp_fire_s) begin
                discard_r <= 1'b0;
            end else if (redirect_act_s && ((state_r == ST_WAIT) || req_fire_s)) begin
                discard_r <= 1'b1;
            end else begin
                discard_r <= discard_r;
            end
        end
    end

    inst_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_act_s),
        .push      (push_s),
        .push_data ({imem_rdata, fetch_pc_r}),
        .pop       (inst_ready),
        .head_data (head_s),
        .not_empty (inst_valid),
        .count     (fifo_count_s)
    );

    // Split the head entry into instruction word and its PC.
    always_comb begin
        inst    = head_s[63:32];
        inst_pc = head_s[31:0];
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    localparam int          FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        halted;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halted         (halted)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: program-order stream and memory state.
    logic [31:0] req_pc, exp_pc, pending_addr, last_hs_addr, last_pop_pc;
    logic        pending, last_rsp;
    int          lat_cnt, hs_count, pops;

    // Stimulus knobs (applied to DUT inputs at the falling edge).
    int          ready_mode, lat_min, lat_max;
    logic        rnd_inst_ready, rnd_redirect, const_data;
    logic        rst_req, halt_req, redir_req, inst_ready_req;
    logic [31:0] redir_pc_req;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (const_data) return 32'h0010_0093;
        return (a ^ 32'h5A5A_1234) + 32'h0000_0013;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        req_pc   = RESET_PC;
        exp_pc   = RESET_PC;
        pending  = 1'b0;
        lat_cnt  = 0;
        hs_count = 0;
        pops     = 0;
        last_rsp = 1'b0;
    endtask

    // One clock: drive at negedge, check handshakes/pops, advance model after posedge.
    task automatic tick();
        logic        hs, pop, rsp, redir, in_rst;
        logic [31:0] hs_addr;
        @(negedge clk);
        rst_n          = rst_req;
        halt           = halt_req;
        redirect_valid = rnd_redirect ? ($urandom_range(0, 99) < 4) : redir_req;
        redirect_pc    = rnd_redirect ? $urandom : redir_pc_req;
        redir_req      = 1'b0;
        inst_ready     = rnd_inst_ready ? ($urandom_range(0, 1) == 1) : inst_ready_req;
        imem_rsp_valid = 1'b0;
        imem_rdata     = $urandom;
        if (pending) begin
            if (lat_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rdata     = mem_data(pending_addr);
            end else begin
                lat_cnt--;
            end
        end
        case (ready_mode)
            0:       imem_req_ready = 1'b0;
            1:       imem_req_ready = 1'b1;
            default: imem_req_ready = ($urandom_range(0, 99) < 70);
        endcase
        hs      = imem_req_valid && imem_req_ready;
        hs_addr = imem_addr;
        pop     = inst_valid && inst_ready;
        rsp     = imem_rsp_valid;
        in_rst  = !rst_n;
        redir   = redirect_valid && !halted;
        if (hs && !in_rst) begin
            check("req_addr", imem_addr, req_pc);
            check("one_outstanding", 32'(pending), 32'd0);
        end
        if (pop && !in_rst) begin
            check("inst_pc", inst_pc, exp_pc);
            check("inst_word", inst, mem_data(exp_pc));
        end
        @(posedge clk);
        #1;
        if (in_rst) begin
            model_reset();
        end else begin
            last_rsp = rsp;
            if (rsp) pending = 1'b0;
            if (hs) begin
                pending      = 1'b1;
                pending_addr = hs_addr;
                lat_cnt      = $urandom_range(lat_min, lat_max);
                hs_count++;
                last_hs_addr = hs_addr;
            end
            if (pop) begin
                pops++;
                last_pop_pc = exp_pc;
                exp_pc      = exp_pc + 32'd4;
            end
            if (redir) begin
                exp_pc = word_align(redirect_pc);
                req_pc = exp_pc;
            end else if (hs) begin
                req_pc = req_pc + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        rst_req  = 1'b0;
        halt_req = 1'b0;
        tick();
        tick();
        rst_req  = 1'b1;
    endtask

    task automatic run_until_hs(input int n, input int budget, input string tag);
        int k = 0;
        while (hs_count < n && k < budget) begin tick(); k++; end
        check(tag, 32'(hs_count >= n), 32'd1);
    endtask

    task automatic run_until_pops(input int n, input int budget, input string tag);
        int k = 0;
        while (pops < n && k < budget) begin tick(); k++; end
        check(tag, 32'(pops >= n), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rdata = 32'd0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; halt = 1'b0;
        ready_mode = 1; lat_min = 0; lat_max = 0;
        rnd_inst_ready = 1'b0; rnd_redirect = 1'b0; const_data = 1'b1;
        rst_req = 1'b0; halt_req = 1'b0; redir_req = 1'b0; inst_ready_req = 1'b0;
        redir_pc_req = 32'd0; last_hs_addr = 32'd0; last_pop_pc = 32'd0; pending_addr = 32'd0;
        model_reset();

        // Reset values
        do_reset();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        // Zero-wait memory: first instruction and its latency
        inst_ready_req = 1'b1;
        begin
            int k = 0;
            while (!inst_valid && k < 20) begin tick(); k++; end
        end
        check("first_valid", 32'(inst_valid), 32'd1);
        check("first_latency", 32'(last_rsp), 32'd1);
        check("first_pc", inst_pc, 32'h8000_0000);
        check("first_inst", inst, 32'h0010_0093);
        run_until_pops(2, 20, "second_pop_seen");
        check("second_pc", last_pop_pc, 32'h8000_0004);
        const_data = 1'b0;

        // Back-pressure: buffer fills to FIFO_DEPTH, no more requests, nothing lost
        do_reset();
        inst_ready_req = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("full_hs_count", hs_count, FIFO_DEPTH);
        check("full_no_req", 32'(imem_req_valid), 32'd0);
        check("full_valid", 32'(inst_valid), 32'd1);
        inst_ready_req = 1'b1;
        run_until_pops(FIFO_DEPTH + 2, 40, "drain_pops");

        // Redirect while waiting: stale response dropped, flush visible next cycle
        do_reset();
        inst_ready_req = 1'b0;
        run_until_hs(1, 10, "redir_hs1");
        lat_min = 3; lat_max = 3;
        run_until_hs(2, 10, "redir_hs2");
        check("redir_pre_valid", 32'(inst_valid), 32'd1);
        redir_req = 1'b1; redir_pc_req = 32'h8000_0102;
        tick();
        check("redir_flush", 32'(inst_valid), 32'd0);
        inst_ready_req = 1'b1; lat_min = 0; lat_max = 0;
        run_until_hs(3, 20, "redir_hs3");
        check("redir_addr", last_hs_addr, 32'h8000_0100);
        run_until_pops(1, 20, "redir_pop");
        check("redir_pop_pc", last_pop_pc, 32'h8000_0100);

        // Request stalled by imem_req_ready=0: address stable, one handshake
        do_reset();
        ready_mode = 0; lat_min = 4; lat_max = 4;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (imem_req_valid) check("stall_addr", imem_addr, 32'h8000_0000);
        end
        check("stall_valid", 32'(imem_req_valid), 32'd1);
        ready_mode = 1;
        run_until_hs(1, 5, "stall_hs");
        ready_mode = 0;
        for (int i = 0; i < 8; i++) tick();
        check("stall_hs_count", hs_count, 32'd1);
        check("stall_hs_addr", last_hs_addr, 32'h8000_0000);
        check("stall_next_addr", imem_addr, 32'h8000_0004);

        // Halt while waiting: response still pushed, then terminal HALT
        do_reset();
        ready_mode = 1; lat_min = 2; lat_max = 2; inst_ready_req = 1'b0;
        run_until_hs(1, 10, "halt_hs");
        halt_req = 1'b1;
        tick();
        check("halt_wait_not_halted", 32'(halted), 32'd0);
        begin
            int k = 0;
            while (!last_rsp && k < 10) begin tick(); k++; end
        end
        check("halt_rsp_seen", 32'(last_rsp), 32'd1);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_pushed", 32'(inst_valid), 32'd1);
        check("halt_pushed_pc", inst_pc, 32'h8000_0000);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("halt_no_req", 32'(imem_req_valid), 32'd0);
        end
        redir_req = 1'b1; redir_pc_req = 32'h1234_5678;
        tick();
        check("halt_redir_ignored", 32'(inst_valid), 32'd1);
        check("halt_still_halted", 32'(halted), 32'd1);
        inst_ready_req = 1'b1;
        run_until_pops(1, 5, "halt_drain");
        tick();
        check("empty_valid", 32'(inst_valid), 32'd0);
        check("empty_hold_pc", inst_pc, 32'h8000_0000);
        check("empty_hold_inst", inst, mem_data(32'h8000_0000));
        check("halt_final_no_req", 32'(imem_req_valid), 32'd0);
        halt_req = 1'b0;

        // PC wrap at the top of the address space
        do_reset();
        lat_min = 0; lat_max = 0; inst_ready_req = 1'b1;
        redir_req = 1'b1; redir_pc_req = 32'hFFFF_FFFC;
        run_until_hs(1, 10, "wrap_hs1");
        check("wrap_first", last_hs_addr, 32'hFFFF_FFFC);
        run_until_hs(2, 10, "wrap_hs2");
        check("wrap_next", last_hs_addr, 32'h0000_0000);

        // Randomized traffic against the reference stream
        do_reset();
        ready_mode = 2; lat_min = 0; lat_max = 3;
        rnd_inst_ready = 1'b1; rnd_redirect = 1'b1;
        for (int i = 0; i < 3000; i++) tick();
        check("random_progress", 32'(pops > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
